// File: rtl/req_staging_queue_if.sv
// Handshake bundle between the request staging queue, its requesters and the
// fixed-priority arbiter.
//   push/push_tag       : per-channel enqueue strobe and token tag (channel i at [i*TAG_W +: TAG_W])
//   full                : per-channel FIFO full flag
//   request/grant       : request vector to the arbiter, one-hot grant back
//   served_valid/ch/tag : token popped on the previous edge
//   overflow/grant_err  : sticky error flags
// The master modport is the requester/arbiter side; the slave modport is the queue.
interface req_staging_queue_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned TAG_W  = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       push;
    logic [NUM_CH*TAG_W-1:0] push_tag;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       request;
    logic [NUM_CH-1:0]       grant;
    logic                    served_valid;
    logic [CH_W-1:0]         served_ch;
    logic [TAG_W-1:0]        served_tag;
    logic                    overflow;
    logic                    grant_err;

    modport master (
        output push, push_tag, grant,
        input  full, request, served_valid, served_ch, served_tag, overflow, grant_err
    );

    modport slave (
        input  push, push_tag, grant,
        output full, request, served_valid, served_ch, served_tag, overflow, grant_err
    );
endinterface

// File: rtl/req_staging_queue.sv
// Request staging queue: per-channel token FIFOs feeding a fixed-priority arbiter.
// Each non-empty channel raises its request bit; a legal one-hot grant pops that
// channel's head token, which is presented as a served token one cycle later.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards all queued tokens
//   bus   : req_staging_queue_if.slave (push/push_tag/full, request/grant,
//           served_valid/served_ch/served_tag, overflow, grant_err)
module req_staging_queue #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 4
) (
    input logic                clk,
    input logic                rst_n,
    req_staging_queue_if.slave bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [CNT_W-1:0] count_q  [NUM_CH];

    logic             served_valid_q;
    logic [CH_W-1:0]  served_ch_q;
    logic [TAG_W-1:0] served_tag_q;
    logic             overflow_q;
    logic             grant_err_q;

    logic [NUM_CH-1:0] request;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push_ok;
    logic [NUM_CH-1:0] drop;
    logic              grant_legal;
    logic              grant_bad;
    logic [CH_W-1:0]   sel;

    // Flags decode registered counts only, so request/full never depend on push or grant.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            request[i] = (count_q[i] != '0);
            full[i]    = (count_q[i] == CNT_W'(DEPTH));
        end
    end

    always_comb begin
        grant_legal = $onehot(bus.grant) && ((bus.grant & request) != '0);
        grant_bad   = (bus.grant != '0) && !grant_legal;
        pop         = grant_legal ? bus.grant : '0;
        sel         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.grant[i]) sel = CH_W'(i);
        end
        // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
        for (int i = 0; i < NUM_CH; i++) begin
            push_ok[i] = bus.push[i] && (!full[i] || pop[i]);
            drop[i]    = bus.push[i] && !push_ok[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            served_valid_q <= 1'b0;
            served_ch_q    <= '0;
            served_tag_q   <= '0;
            overflow_q     <= 1'b0;
            grant_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                if (push_ok[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + CNT_W'(1);
                end else if (!push_ok[i] && pop[i]) begin
                    count_q[i] <= count_q[i] - CNT_W'(1);
                end
            end
            served_valid_q <= grant_legal;
            if (grant_legal) begin
                served_ch_q  <= sel;
                served_tag_q <= mem_q[sel][rd_ptr_q[sel]];
            end
            if (drop != '0) overflow_q  <= 1'b1;
            if (grant_bad)  grant_err_q <= 1'b1;
        end
    end

    // Tag storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= bus.push_tag[i*TAG_W +: TAG_W];
        end
    end

    assign bus.request      = request;
    assign bus.full         = full;
    assign bus.served_valid = served_valid_q;
    assign bus.served_ch    = served_ch_q;
    assign bus.served_tag   = served_tag_q;
    assign bus.overflow     = overflow_q;
    assign bus.grant_err    = grant_err_q;
endmodule

// File: doc/req_staging_queue.md
Name: req_staging_queue

Overview:
- Upstream stage of the fixed-priority arbiter.
- Collects request tokens from NUM_CH requesters into per-channel FIFOs and drives the arbiter's request vector, one bit per non-empty channel.
- Consumes the arbiter's one-hot grant vector, pops the granted channel's head token, and presents it one cycle later as a served token.

Parameters:
NUM_CH, 2, number of requester channels (the arbiter request width)
DEPTH, 4, per-channel FIFO depth; power of two, >= 2
TAG_W, 4, width of the tag carried by each request token

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
push  input  NUM_CH  per-channel push strobe; bit i enqueues push_tag slice i
push_tag  input  NUM_CH*TAG_W  per-channel token tags; channel i uses bits [i*TAG_W +: TAG_W]
full  output  NUM_CH  per-channel FIFO full flag
request  output  NUM_CH  to arbiter; bit i = channel i FIFO non-empty
grant  input  NUM_CH  from arbiter; one-hot, pops head of the granted channel
served_valid  output  1  a token was popped on the previous edge
served_ch  output  clog2(NUM_CH) (min 1)  channel index of the served token
served_tag  output  TAG_W  tag of the served token
overflow  output  1  sticky; a push was dropped
grant_err  output  1  sticky; an illegal grant was received

Behaviour:
- Reset (async, rst_n=0):
  - All FIFO pointers and counts go to 0.
  - request=0, full=0, served_valid=0, served_ch=0, served_tag=0, overflow=0, grant_err=0.
  - Reset mid-operation discards all queued tokens; no token is served after deassert.
- State:
  - Per channel: a DEPTH-entry tag array, rd_ptr and wr_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), and count (0..DEPTH).
  - request[i] = (count_i != 0) and full[i] = (count_i == DEPTH). Both are decoded from registered state only; there is no combinational path from push or grant.
- Push:
  - When push[i]=1 and count_i<DEPTH, the tag is written at wr_ptr_i on the edge and wr_ptr_i is incremented.
  - Latency: a push at edge N into an empty FIFO gives request[i]=1 from edge N onward (visible in the following cycle).
- Pop: a legal grant is one-hot with request[bit]=1.
  - On the edge, the head tag at rd_ptr_i is captured into served_tag, served_ch=i, served_valid=1, and rd_ptr_i is incremented.
  - served_valid is a single-cycle pulse per grant. Back-to-back grants give consecutive served tokens.
- Illegal grant:
  - Cases: multi-hot grant, or one-hot grant to a channel with request=0.
  - No pop on any channel, served_valid=0, and grant_err is set (sticky until reset).
  - grant=0 is idle and not an error.
- Simultaneous push and pop on the same channel:
  - Both take effect and count is unchanged.
  - When full, the pop frees a slot in the same edge, so the push is accepted and overflow is not set.
  - When count=1, the popped token is the old head. The new token becomes head after the edge and request stays 1.
- Overflow: push[i]=1 while full and not popped on the same edge drops the token, leaves the FIFO unchanged, and sets overflow (sticky).
- Ordering: FIFO order is preserved within a channel. There is no ordering relation between channels; priority is decided by the arbiter.
- Channels are independent. Pushes on all channels plus a pop on one channel in the same edge are all processed.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, release. Required: request=00, full=00, served_valid=0, overflow=0, grant_err=0.
2. Ordered service: push ch0 tags 3,5,9 on consecutive edges, then grant=01 for 3 cycles. Required: request[0]=1 after the first push; served_tag=3,5,9 with served_ch=0 on 3 consecutive cycles; request[0]=0 after the third pop.
3. Full and overflow: push 5 tags 1..5 into ch1 with DEPTH=4. Required: full[1]=1 after the 4th push; tag 5 dropped; overflow=1. Four grant=10 pops then return 1,2,3,4.
4. Push and pop when full: fill ch0 with 1..4, then on one edge push tag 7 with grant=01. Required: served_tag=1, count stays 4, overflow=0. Draining returns 2,3,4,7.
5. Illegal grants: ch0 holds one token, ch1 is empty. Apply grant=10, then grant=11. Required: no pop, served_valid=0, grant_err=1, request stays 01.
6. Reset mid-operation: ch0 and ch1 each hold 2 tokens, assert rst_n=0 asynchronously between edges. Required: request=00 immediately; after release, grant=01 produces no served_valid.
